ob_rd_sched: RTL

//  Read-side scheduler for the 8-bank outbound buffer (ram_x8_ob). Channels post a
//  per-bank "payload ready + length". The block picks one bank round-robin and issues

---
 rtl/ob_sched_pkg.sv | 32 +++
 rtl/ob_sched_fifo2.sv | 43 ++++
 rtl/ob_rd_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ob_sched_pkg.sv
// Shared types and constants for the outbound-buffer read scheduler.
// Beat bundle carried from the bank array to the TX port.
package ob_sched_pkg;

  localparam int OB_RAM_NUM  = 8;
  localparam int OB_BEAT_AW  = 8;
  localparam int OB_BANK_LSB = 8;
  localparam int OB_MAX_LEN  = 256;
  localparam int OB_DW       = 128;
  localparam int OB_LEN_W    = 9;
  localparam int OB_BANK_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_st_e;

  typedef struct packed {
    logic [OB_DW-1:0]     data;
    logic                 last;
    logic [OB_BANK_W-1:0] bank;
  } ob_beat_t;

  function automatic logic [OB_LEN_W-1:0] ob_clamp_len(
    input logic [OB_LEN_W-1:0] len
  );
    if (len > OB_LEN_W'(OB_MAX_LEN)) return OB_LEN_W'(OB_MAX_LEN);
    return len;
  endfunction

endpackage

// File: rtl/ob_sched_fifo2.sv
// Two-entry beat FIFO between the bank array and the TX port.
// Push and pop may coincide; flush empties it synchronously.
module ob_sched_fifo2
  import ob_sched_pkg::*;
(
  input  logic       clk,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  ob_beat_t   din_i,
  output logic       vld_o,
  output ob_beat_t   dout_o,
  output logic [1:0] cnt_o
);

  ob_beat_t   mem_q [2];
  logic       wp_q;
  logic       rp_q;
  logic [1:0] cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= !wp_q;
      end
      if (pop_i) rp_q <= !rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign vld_o  = (cnt_q != 2'd0);
  assign dout_o = mem_q[rp_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ob_rd_sched.sv
// Round-robin read scheduler for the 8-bank outbound buffer.
// Drains one granted bank at a time into a valid/ready TX port.
module ob_rd_sched
  import ob_sched_pkg::*;
#(
  parameter int RAM_NUM = OB_RAM_NUM,
  parameter int DW      = OB_DW,
  parameter int LEN_W   = OB_LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RAM_NUM-1:0]       ReqVld,
  input  logic [RAM_NUM*LEN_W-1:0] ReqLen,
  output logic [RAM_NUM-1:0]       ReqAck,
  output logic                     RdEn,
  output logic [31:0]              RdAddr,
  input  logic [DW-1:0]            RdData,
  output logic                     TxVld,
  output logic [DW-1:0]            TxData,
  output logic                     TxLast,
  output logic [2:0]               TxBank,
  input  logic                     TxRdy,
  output logic                     Busy
);

  sched_st_e          st_q, st_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         bank_q, bank_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [7:0]         lbeat_q, lbeat_d;
  logic [RAM_NUM-1:0] ack_q, ack_d;
  logic               rdv_q;
  logic               rdv_last_q;

  logic [RAM_NUM-1:0] req_m;
  logic               gnt_vld;
  logic [2:0]         gnt_idx;
  logic [2:0]         cand;
  logic [LEN_W-1:0]   gnt_len;
  logic               rd_c;
  logic               is_last;
  logic               done_c;
  logic               pop;
  logic [2:0]         occ;
  logic               f_vld;
  logic [1:0]         f_cnt;
  ob_beat_t           f_in;
  ob_beat_t           f_out;
  ob_beat_t           head;

  // A bank being acked this cycle is not eligible until next IDLE pass.
  assign req_m = ReqVld & ~ack_q;

  // Round-robin search upward from ptr+1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 1; i <= RAM_NUM; i++) begin
      cand = ptr_q + 3'(i);
      if (!gnt_vld && req_m[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_len = ob_clamp_len(ReqLen[gnt_idx*LEN_W +: LEN_W]);

  assign pop     = f_vld & TxRdy;
  assign occ     = {1'b0, f_cnt} + {2'b0, rdv_q} - {2'b0, pop};
  assign rd_c    = (st_q == RUN) && (occ < 3'd2);
  assign is_last = (beat_q == len_q - LEN_W'(1));
  assign done_c  = !rdv_q && (occ == 3'd0);

  // Next-state logic for grant, beat issue and release.
  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    bank_d  = bank_q;
    len_d   = len_q;
    beat_d  = beat_q;
    lbeat_d = lbeat_q;
    ack_d   = '0;
    unique case (st_q)
      IDLE: begin
        if (gnt_vld) begin
          bank_d = gnt_idx;
          len_d  = gnt_len;
          beat_d = '0;
          st_d   = (gnt_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (rd_c) begin
          lbeat_d = beat_q[7:0];
          beat_d  = beat_q + LEN_W'(1);
          if (is_last) st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done_c) begin
          ack_d[bank_q] = 1'b1;
          ptr_d         = bank_q;
          st_d          = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State register plus the one-cycle read-return stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      ptr_q      <= 3'(RAM_NUM - 1);
      bank_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      lbeat_q    <= '0;
      ack_q      <= '0;
      rdv_q      <= 1'b0;
      rdv_last_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      ptr_q      <= ptr_d;
      bank_q     <= bank_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      lbeat_q    <= lbeat_d;
      ack_q      <= ack_d;
      rdv_q      <= rd_c;
      rdv_last_q <= rd_c && is_last;
    end
  end

  assign f_in.data = RdData;
  assign f_in.last = rdv_last_q;
  assign f_in.bank = bank_q;

  ob_sched_fifo2 u_fifo (
    .clk     (clk),
    .flush_i (rst),
    .push_i  (rdv_q),
    .pop_i   (pop),
    .din_i   (f_in),
    .vld_o   (f_vld),
    .dout_o  (f_out),
    .cnt_o   (f_cnt)
  );

  assign head   = f_vld ? f_out : '0;
  assign TxVld  = f_vld;
  assign TxData = head.data;
  assign TxLast = head.last;
  assign TxBank = head.bank;

  assign RdEn   = rd_c;
  assign RdAddr = {20'h0, 1'b0, bank_q, rd_c ? beat_q[7:0] : lbeat_q};
  assign ReqAck = ack_q;
  assign Busy   = (st_q != IDLE);

endmodule
